// File: rtl/pe_pkg.sv
// Shared widths, signed types and saturation limits for the systolic processing element.
package pe_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [PROD_W-1:0] product_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam acc_t     ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t     ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam operand_t OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam operand_t OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/pe_sat.sv
// Signed saturating narrower: clamps a signed IN_W value into the signed OUT_W range.
module pe_sat #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  generate
    if (IN_W > OUT_W) begin : g_clamp
      // Value fits only if every bit from the output sign bit upward agrees.
      logic [IN_W-OUT_W:0] upper;
      logic                fits;

      assign upper = din[IN_W-1:OUT_W-1];
      assign fits  = (&upper) | ~(|upper);

      always_comb begin
        dout = din[OUT_W-1:0];
        if (!fits) begin
          dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                             : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end else begin : g_extend
      assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
    end
  endgenerate

endmodule

// File: rtl/pe.sv
// Output-stationary systolic PE: forwards operands east/south and accumulates a saturating MAC.
module pe #(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ACC_W  = pe_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [DATA_W-1:0] c_out
);

  import pe_pkg::*;

  localparam int P_W   = 2 * DATA_W;
  localparam int SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

  logic signed [DATA_W-1:0] a_q, b_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sat;
  logic signed [P_W-1:0]    prod;
  logic signed [SUM_W-1:0]  sum;

  // Full-width signed product keeps -128 * -128 exact.
  assign prod = a_in * b_in;
  assign sum  = $signed({{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q})
              + $signed({{(SUM_W-P_W){prod[P_W-1]}}, prod});

  pe_sat #(.IN_W(SUM_W), .OUT_W(ACC_W)) u_acc_sat (
    .din  (sum),
    .dout (acc_sat)
  );

  always_comb begin
    acc_d = acc_sat;
    if (clear) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;

  // Byte-wide results are clamped; other widths expose the low accumulator bits.
  generate
    if (DATA_W == 8) begin : g_out_sat
      pe_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_out_sat (
        .din  (acc_q),
        .dout (c_out)
      );
    end else begin : g_out_trunc
      assign c_out = acc_q[DATA_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_pe.sv
// Directed self-checking bench for pe: reset, forwarding, dot product, saturation, clear.
module tb_pe;

  logic              clk;
  logic              rst;
  logic              clear;
  logic signed [7:0] a_in, b_in;
  logic signed [7:0] a_out, b_out, c_out;

  int n_cmp;
  int n_bad;

  pe #(.DATA_W(8), .ACC_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .a_in  (a_in),
    .b_in  (b_in),
    .a_out (a_out),
    .b_out (b_out),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic signed [7:0] got,
                      input logic signed [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)", name, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic chk_acc(input string name, input logic signed [15:0] exp);
    n_cmp++;
    if (dut.acc_q !== exp) begin
      n_bad++;
      $display("FAIL %s: acc got %0d expected %0d", name, $signed(dut.acc_q), exp);
    end else begin
      $display("ok   %s acc = %0d", name, exp);
    end
  endtask

  task automatic mac(input logic signed [7:0] a, input logic signed [7:0] b);
    clear = 1'b0;
    a_in  = a;
    b_in  = b;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    a_in  = 8'sd0;
    b_in  = 8'sd0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    clear = 1'b0;
    a_in  = 8'sd5;
    b_in  = 8'sd3;
    #3;
    chk8("reset a_out", a_out, 8'sd0);
    chk8("reset b_out", b_out, 8'sd0);
    chk8("reset c_out", c_out, 8'sd0);
    tick();
    chk8("reset held c_out", c_out, 8'sd0);
    #2 rst = 1'b1;
  endtask

  task automatic test_forwarding();
    mac(8'sd7, -8'sd2);
    chk8("fwd a_out", a_out, 8'sd7);
    chk8("fwd b_out", b_out, 8'shFE);
    chk8("fwd c_out", c_out, 8'shF2);
  endtask

  task automatic test_dot_product();
    do_clear();
    chk_acc("dot clear", 16'sd0);
    mac(8'sd1, 8'sd2);
    chk8("dot step1", c_out, 8'sd2);
    mac(8'sd3, 8'sd4);
    chk8("dot step2", c_out, 8'sd14);
    mac(8'sd5, 8'sd6);
    chk8("dot step3", c_out, 8'sd44);
  endtask

  task automatic test_saturation();
    do_clear();
    mac(8'sd127, 8'sd127);
    chk8("sat1 c_out", c_out, 8'sd127);
    chk_acc("sat1", 16'sd16129);
    mac(8'sd127, 8'sd127);
    chk_acc("sat2", 16'sd32258);
    mac(8'sd127, 8'sd127);
    chk8("sat3 c_out", c_out, 8'sd127);
    chk_acc("sat3", 16'sd32767);
    mac(8'sd127, 8'sd127);
    chk_acc("sat hold", 16'sd32767);
    mac(-8'sd128, 8'sd127);
    chk_acc("sat back", 16'sd16511);
    chk8("sat back c_out", c_out, 8'sd127);
  endtask

  task automatic test_neg_clamp();
    do_clear();
    mac(-8'sd128, 8'sd127);
    chk8("neg c_out", c_out, -8'sd128);
    chk_acc("neg", -16'sd16256);
    mac(-8'sd128, -8'sd128);
    chk_acc("minmin exact", 16'sd128);
    chk8("minmin c_out", c_out, 8'sd127);
    do_clear();
    mac(-8'sd128, 8'sd127);
    mac(-8'sd128, 8'sd127);
    mac(-8'sd128, 8'sd127);
    chk_acc("neg sat", -16'sd32768);
    mac(-8'sd128, 8'sd127);
    chk_acc("neg sat hold", -16'sd32768);
    mac(8'sd1, 8'sd1);
    chk_acc("neg sat back", -16'sd32767);
  endtask

  task automatic test_clear_reset();
    do_clear();
    mac(8'sd3, 8'sd3);
    chk_acc("pre clear", 16'sd9);
    clear = 1'b1;
    a_in  = 8'sd9;
    b_in  = 8'sd9;
    tick();
    clear = 1'b0;
    chk_acc("clear discards", 16'sd0);
    chk8("clear a_out", a_out, 8'sd9);
    chk8("clear c_out", c_out, 8'sd0);
    mac(8'sd4, 8'sd5);
    chk8("pre rst c_out", c_out, 8'sd20);
    #2 rst = 1'b0;
    #1;
    chk8("async rst c_out", c_out, 8'sd0);
    chk8("async rst a_out", a_out, 8'sd0);
    clear = 1'b1;
    a_in  = 8'sd1;
    b_in  = 8'sd1;
    tick();
    chk8("rst over clear a_out", a_out, 8'sd0);
    chk_acc("rst over clear", 16'sd0);
    #2 rst = 1'b1;
    mac(8'sd2, 8'sd3);
    chk8("restart c_out", c_out, 8'sd6);
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] va [4];
    logic signed [7:0] vb [4];
    va = '{8'sd10, -8'sd1, -8'sd128, 8'sd127};
    vb = '{-8'sd3, 8'sd50, 8'sd0, -8'sd128};
    for (int i = 0; i < 4; i++) begin
      mac(va[i], vb[i]);
      chk8($sformatf("b2b a_out[%0d]", i), a_out, va[i]);
      chk8($sformatf("b2b b_out[%0d]", i), b_out, vb[i]);
    end
    // 6 - 30 - 50 + 0 - 16256 = -16330, clamped to -128 on c_out
    chk_acc("b2b acc", -16'sd16330);
    chk8("b2b c_out", c_out, -8'sd128);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_forwarding();
    test_dot_product();
    test_saturation();
    test_neg_clamp();
    test_clear_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
